// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: register-address width,
// operand-forwarding select encodings, control FSM states and the source
// match helper used by both the stall and forwarding logic.
package hazard_unit_pkg;

  localparam int REG_ADDR_W  = 4;
  localparam int FLUSH_CNT_W = 2;

  // EX operand source select; 2'b11 is never produced.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } hz_state_e;

  // A consumer source matches a producer when the source is actually read,
  // the producer writes, and the addresses agree. Register 0 is not special.
  function automatic logic src_match(
    input logic                  used,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd,
    input logic                  wen
  );
    return used & wen & (rs == rd);
  endfunction

  // Forwarding source for one EX operand; the younger MEM result wins over WB.
  function automatic fwd_sel_e fwd_pick(
    input logic [REG_ADDR_W-1:0] ex_rs,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic                  mem_wen,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic                  wb_wen
  );
    fwd_sel_e sel;
    if (mem_wen && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_wen && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Enabled up-counter that sticks at all-ones instead of wrapping.
// Asynchronous active-high reset clears it to zero.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles, holding at the maximum value once reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use / RAW stall detection, branch flush
// sequencing and EX operand forwarding selects, plus two saturating
// performance counters (stall cycles, flush events).
// Build option: define HAZARD_FWD_EN to enable operand forwarding; without
// it the unit stalls on any RAW dependency against EX, MEM or WB and the
// forwarding selects stay at register-file data.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_wen,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_wen,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_wen,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic [1:0]            fwd_sel1,
  output logic [1:0]            fwd_sel2,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  // The branch cycle itself is flushed combinationally, so the FLUSH state
  // only has to cover the remaining FLUSH_CYCLES-1 cycles.
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  hz_state_e               r_state;
  hz_state_e               w_state_nxt;
  logic [FLUSH_CNT_W-1:0]  r_flush_cnt;
  logic [FLUSH_CNT_W-1:0]  w_flush_cnt_nxt;
  logic                    w_flush;
  logic                    w_hazard;
  logic                    w_stall;
  logic                    w_flush_evt;
  logic [1:0]              w_fwd_sel1;
  logic [1:0]              w_fwd_sel2;
  logic                    w_ex_hit;

  // State and flush counter register; reset abandons any flush in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Flush sequencing: a taken branch (re)loads the counter; in FLUSH the
  // counter steps down and the FSM leaves once it would reach zero.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      ST_RUN: begin
        if (branch_taken && (FLUSH_LOAD != '0)) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = FLUSH_LOAD;
        end else begin
          w_state_nxt     = ST_RUN;
          w_flush_cnt_nxt = '0;
        end
      end
      ST_FLUSH: begin
        if (branch_taken) begin
          if (FLUSH_LOAD != '0) begin
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = FLUSH_LOAD;
          end else begin
            w_state_nxt     = ST_RUN;
            w_flush_cnt_nxt = '0;
          end
        end else if (r_flush_cnt <= FLUSH_CNT_W'(1)) begin
          w_state_nxt     = ST_RUN;
          w_flush_cnt_nxt = '0;
        end else begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = r_flush_cnt - FLUSH_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_flush_cnt_nxt = '0;
      end
    endcase
  end

  // Any use of the EX destination by the ID instruction.
  assign w_ex_hit = src_match(id_rs1_used, id_rs1, ex_rd, ex_wen) |
                    src_match(id_rs2_used, id_rs2, ex_rd, ex_wen);

`ifdef HAZARD_FWD_EN
  // Forwarding build: only a load in EX cannot be bypassed in time.
  always_comb begin
    w_hazard   = ex_is_load & w_ex_hit;
    w_fwd_sel1 = fwd_pick(ex_rs1, mem_rd, mem_wen, wb_rd, wb_wen);
    w_fwd_sel2 = fwd_pick(ex_rs2, mem_rd, mem_wen, wb_rd, wb_wen);
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{ex_rs1, ex_rs2, ex_is_load};

  // No-forwarding build: wait until every in-flight producer has retired.
  always_comb begin
    w_hazard   = w_ex_hit |
                 src_match(id_rs1_used, id_rs1, mem_rd, mem_wen) |
                 src_match(id_rs2_used, id_rs2, mem_rd, mem_wen) |
                 src_match(id_rs1_used, id_rs1, wb_rd, wb_wen) |
                 src_match(id_rs2_used, id_rs2, wb_rd, wb_wen);
    w_fwd_sel1 = FWD_RF;
    w_fwd_sel2 = FWD_RF;
  end
`endif

  // Pipeline control: flush beats stall, and both are quiet during reset.
  always_comb begin
    w_flush     = ~rst & (branch_taken | (r_state == ST_FLUSH));
    w_stall     = ~rst & ~w_flush & w_hazard;
    w_flush_evt = ~rst & branch_taken;
  end

  assign stall    = w_stall;
  assign flush    = w_flush;
  assign fwd_sel1 = w_fwd_sel1;
  assign fwd_sel2 = w_fwd_sel2;

  hazard_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_stall),
    .o_count (stall_cycles)
  );

  hazard_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_flush_evt),
    .o_count (flush_events)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit. Stimulus pushes hand-computed
// expectations per cycle; a negedge monitor pops and compares them.
// A second instance (CNT_W=2, FLUSH_CYCLES=3) exercises counter saturation.
module tb_hazard_unit;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic        stall;
    logic        flush;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [15:0] sc;
    logic [15:0] fe;
    bit          chk_sat;
    logic [1:0]  ssc;
    logic [1:0]  sfe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_rs1_used, id_rs2_used, ex_wen, ex_is_load, mem_wen, wb_wen;
  logic        branch_taken;
  logic        stall, flush;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [15:0] stall_cycles, flush_events;
  logic        s_stall, s_flush;
  logic [1:0]  s_fwd1, s_fwd2;
  logic [1:0]  s_sc, s_fe;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_sc = 0;
  int          exp_fe = 0;
  bit          chk_sat_next = 1'b0;

  always #5 clk = ~clk;

  hazard_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_wen(ex_wen),
    .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_wen(mem_wen),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .branch_taken(branch_taken),
    .stall(stall), .flush(flush), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  hazard_unit #(.FLUSH_CYCLES(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_wen(ex_wen),
    .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_wen(mem_wen),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .branch_taken(branch_taken),
    .stall(s_stall), .flush(s_flush), .fwd_sel1(s_fwd1), .fwd_sel2(s_fwd2),
    .stall_cycles(s_sc), .flush_events(s_fe)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation against the outputs mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("stall", {15'd0, stall}, {15'd0, e.stall});
      chk("flush", {15'd0, flush}, {15'd0, e.flush});
      chk("fwd_sel1", {14'd0, fwd_sel1}, {14'd0, e.f1});
      chk("fwd_sel2", {14'd0, fwd_sel2}, {14'd0, e.f2});
      chk("stall_cycles", stall_cycles, e.sc);
      chk("flush_events", flush_events, e.fe);
      if (e.chk_sat) begin
        chk("sat_stall_cycles", {14'd0, s_sc}, {14'd0, e.ssc});
        chk("sat_flush_events", {14'd0, s_fe}, {14'd0, e.sfe});
      end
    end
  end

  task automatic clr();
    id_rs1 = 4'd0; id_rs2 = 4'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rs1 = 4'd0; ex_rs2 = 4'd0; ex_rd = 4'd0; ex_wen = 1'b0; ex_is_load = 1'b0;
    mem_rd = 4'd0; mem_wen = 1'b0; wb_rd = 4'd0; wb_wen = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic push(input logic s, input logic f, input logic [1:0] f1, input logic [1:0] f2);
    exp_t e;
    e.stall = s; e.flush = f; e.f1 = f1; e.f2 = f2;
    e.sc = 16'(exp_sc); e.fe = 16'(exp_fe);
    e.chk_sat = chk_sat_next; e.ssc = 2'd3; e.sfe = 2'd3;
    sb_q.push_back(e);
  endtask

  // One cycle with current inputs; counter expectations advance after the edge.
  task automatic cyc(input logic s, input logic f, input logic [1:0] f1, input logic [1:0] f2);
    push(s, f, f1, f2);
    @(posedge clk); #1;
    if (rst) begin
      exp_sc = 0; exp_fe = 0;
    end else begin
      if (s) exp_sc++;
      if (branch_taken) exp_fe++;
    end
  endtask

  initial begin
    rst = 1'b1;
    clr();
    // Reset: hazard and branch present, yet outputs quiet; fwd still live.
    branch_taken = 1'b1; ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 4'd3;
    id_rs1 = 4'd3; id_rs1_used = 1'b1; mem_rd = 4'd5; mem_wen = 1'b1; ex_rs1 = 4'd5;
    @(posedge clk); #1;
    cyc(1'b0, 1'b0, FWD ? 2'b01 : 2'b00, 2'b00);
    rst = 1'b0; clr();
    cyc(1'b0, 1'b0, 2'b00, 2'b00);

    // Load-use on r3: one stall, then load moves to MEM / WB.
    ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 4'd3; id_rs1 = 4'd3; id_rs1_used = 1'b1;
    cyc(1'b1, 1'b0, 2'b00, 2'b00);
    ex_is_load = 1'b0; ex_wen = 1'b0; ex_rd = 4'd0; mem_rd = 4'd3; mem_wen = 1'b1;
    cyc(!FWD, 1'b0, 2'b00, 2'b00);
    mem_rd = 4'd0; mem_wen = 1'b0; wb_rd = 4'd3; wb_wen = 1'b1;
    cyc(!FWD, 1'b0, 2'b00, 2'b00);
    clr();
    cyc(1'b0, 1'b0, 2'b00, 2'b00);

    // Unused source must not stall; then enable it.
    ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 4'd3; id_rs2 = 4'd3; id_rs1 = 4'd4; id_rs1_used = 1'b1;
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    id_rs2_used = 1'b1;
    cyc(1'b1, 1'b0, 2'b00, 2'b00);
    clr();
    // Register 0 is compared like any other; producer wen gates it.
    ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 4'd0; id_rs1 = 4'd0; id_rs1_used = 1'b1;
    cyc(1'b1, 1'b0, 2'b00, 2'b00);
    ex_wen = 1'b0;
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    clr();

    // Forwarding priority: MEM over WB, then WB, then register file.
    mem_rd = 4'd5; mem_wen = 1'b1; wb_rd = 4'd5; wb_wen = 1'b1; ex_rs1 = 4'd5; ex_rs2 = 4'd5;
    cyc(1'b0, 1'b0, FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00);
    mem_wen = 1'b0;
    cyc(1'b0, 1'b0, FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00);
    wb_wen = 1'b0;
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    ex_rs1 = 4'd15; mem_rd = 4'd15; mem_wen = 1'b1; ex_rs2 = 4'd9; wb_rd = 4'd9; wb_wen = 1'b1;
    cyc(1'b0, 1'b0, FWD ? 2'b01 : 2'b00, FWD ? 2'b10 : 2'b00);
    clr();

    // Branch: two flush cycles; a second branch extends it to three.
    branch_taken = 1'b1;
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    branch_taken = 1'b0;
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    branch_taken = 1'b1;
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    branch_taken = 1'b0;
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 2'b00, 2'b00);

    // Flush overrides a simultaneous load-use stall.
    ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 4'd6; id_rs1 = 4'd6; id_rs1_used = 1'b1; branch_taken = 1'b1;
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    branch_taken = 1'b0;
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    clr();
    cyc(1'b0, 1'b0, 2'b00, 2'b00);

    // Asynchronous reset in the first FLUSH cycle.
    branch_taken = 1'b1;
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    branch_taken = 1'b0;
    #2; rst = 1'b1;
    exp_sc = 0; exp_fe = 0;
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    branch_taken = 1'b1;
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    branch_taken = 1'b0;
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 2'b00, 2'b00);

    // ALU write r7 walking EX -> MEM -> WB, read by ID rs2.
    ex_rd = 4'd7; ex_wen = 1'b1; id_rs2 = 4'd7; id_rs2_used = 1'b1;
    cyc(!FWD, 1'b0, 2'b00, 2'b00);
    ex_rd = 4'd0; ex_wen = 1'b0; mem_rd = 4'd7; mem_wen = 1'b1; ex_rs2 = 4'd7;
    cyc(!FWD, 1'b0, 2'b00, FWD ? 2'b01 : 2'b00);
    mem_rd = 4'd0; mem_wen = 1'b0; wb_rd = 4'd7; wb_wen = 1'b1;
    cyc(!FWD, 1'b0, 2'b00, FWD ? 2'b10 : 2'b00);
    clr();
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 2'b00, 2'b00);

    // Drive both counters past the 2-bit instance's all-ones value.
    ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 4'd2; id_rs1 = 4'd2; id_rs1_used = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 2'b00, 2'b00);
    clr();
    branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 2'b00, 2'b00);
    branch_taken = 1'b0;
    cyc(1'b0, 1'b1, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    chk_sat_next = 1'b1;
    cyc(1'b0, 1'b0, 2'b00, 2'b00);
    chk_sat_next = 1'b0;

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 4; i++) begin
      if (sb_q.size() > 0) @(negedge clk);
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
